// File: rtl/spmv_kernel_ctrl.sv
// spmv_kernel_ctrl: per-kernel run controller for one SpMV compute kernel.
// Decodes start/abort/clear from the ctrl word, launches the kernel,
// tracks row/nnz progress, detects done / nnz mismatch / overrun / timeout
// and reports a 64-bit cycle count plus a flags word.
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   ctrl_word               level-held control register (start/abort/clear)
//   row_num, nnz_num        job size, latched at launch
//   status_word             [63:0] cycle count, [95:64] flags
//   kernel_start/abort      one-cycle pulses to the kernel
//   kernel_row_num/nnz_num  latched job size driven to the kernel
//   kernel_row_done         one pulse per completed row
//   kernel_nnz_beat         one pulse per consumed nonzero
module spmv_kernel_ctrl #(
    parameter logic [63:0] TIMEOUT_CYCLES = 64'd0,
    parameter int          START_BIT      = 0,
    parameter int          ABORT_BIT      = 1,
    parameter int          CLEAR_BIT      = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] ctrl_word,
    input  logic [31:0] row_num,
    input  logic [31:0] nnz_num,
    output logic [95:0] status_word,
    output logic        kernel_start,
    output logic        kernel_abort,
    output logic [31:0] kernel_row_num,
    output logic [31:0] kernel_nnz_num,
    input  logic        kernel_row_done,
    input  logic        kernel_nnz_beat
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t      state;
    logic        start_q;
    logic [63:0] cnt;
    logic [31:0] rows_done;
    logic [31:0] nnz_done;
    logic [1:0]  err_code;
    logic        busy;
    logic        done_flag;
    logic        err_flag;

    logic        start_edge;
    logic        abort;
    logic        clear;
    logic [63:0] cnt_inc;
    logic [31:0] rows_nxt;
    logic [31:0] nnz_nxt;
    logic        overrun;
    logic        complete;
    logic        nnz_match;
    logic        timeout;
    logic        ctrl_unused;

    assign start_edge = ctrl_word[START_BIT] & ~start_q;
    assign abort      = ctrl_word[ABORT_BIT];
    assign clear      = ctrl_word[CLEAR_BIT];
    assign ctrl_unused = ^ctrl_word;

    // Saturating increments; progress values include this cycle's pulse.
    assign cnt_inc  = (&cnt) ? cnt : cnt + 64'd1;
    assign rows_nxt = rows_done + {31'd0, kernel_row_done & ~(&rows_done)};
    assign nnz_nxt  = nnz_done + {31'd0, kernel_nnz_beat & ~(&nnz_done)};

    // A beat arriving once nnz_done already equals the target would exceed it.
    assign overrun   = kernel_nnz_beat & (nnz_done >= kernel_nnz_num);
    assign complete  = (rows_nxt == kernel_row_num);
    assign nnz_match = (nnz_nxt == kernel_nnz_num);
    assign timeout   = (TIMEOUT_CYCLES != 64'd0) && (cnt_inc >= TIMEOUT_CYCLES);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state          <= IDLE;
            start_q        <= 1'b0;
            cnt            <= 64'd0;
            rows_done      <= 32'd0;
            nnz_done       <= 32'd0;
            err_code       <= 2'd0;
            busy           <= 1'b0;
            done_flag      <= 1'b0;
            err_flag       <= 1'b0;
            kernel_start   <= 1'b0;
            kernel_abort   <= 1'b0;
            kernel_row_num <= 32'd0;
            kernel_nnz_num <= 32'd0;
        end else begin
            start_q      <= ctrl_word[START_BIT];
            kernel_start <= 1'b0;
            kernel_abort <= 1'b0;
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start_edge && !abort) begin
                        state          <= LAUNCH;
                        kernel_row_num <= row_num;
                        kernel_nnz_num <= nnz_num;
                        cnt            <= 64'd0;
                        rows_done      <= 32'd0;
                        nnz_done       <= 32'd0;
                        err_code       <= 2'd0;
                        done_flag      <= 1'b0;
                        err_flag       <= 1'b0;
                        busy           <= 1'b1;
                        // Pulse coincides with the LAUNCH cycle.
                        kernel_start   <= (row_num != 32'd0);
                    end else if (clear) begin
                        cnt <= 64'd0;
                    end
                end
                LAUNCH: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        kernel_abort <= 1'b1;
                    end else if (kernel_row_num == 32'd0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done_flag <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        kernel_abort <= 1'b1;
                    end else begin
                        cnt       <= cnt_inc;
                        rows_done <= rows_nxt;
                        nnz_done  <= nnz_nxt;
                        if (overrun) begin
                            state    <= ERROR;
                            busy     <= 1'b0;
                            err_flag <= 1'b1;
                            err_code <= 2'd2;
                        end else if (complete) begin
                            busy <= 1'b0;
                            if (nnz_match) begin
                                state     <= DONE;
                                done_flag <= 1'b1;
                            end else begin
                                state    <= ERROR;
                                err_flag <= 1'b1;
                                err_code <= 2'd1;
                            end
                        end else if (timeout) begin
                            state        <= ERROR;
                            busy         <= 1'b0;
                            err_flag     <= 1'b1;
                            err_code     <= 2'd3;
                            kernel_abort <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign status_word = {rows_done[21:0], err_code, 1'b0, state,
                          1'b0, err_flag, done_flag, busy, cnt};

endmodule

// File: tb/tb_spmv_kernel_ctrl.sv
// tb_spmv_kernel_ctrl: scoreboard bench for spmv_kernel_ctrl.
// Expected run outcomes are queued at launch and checked when busy drops.
module tb_spmv_kernel_ctrl;

    localparam int TMO = 100;

    logic        aclk;
    logic        areset;
    logic [31:0] ctrl_word;
    logic [31:0] row_num;
    logic [31:0] nnz_num;
    logic [95:0] status_word;
    logic        kernel_start;
    logic        kernel_abort;
    logic [31:0] kernel_row_num;
    logic [31:0] kernel_nnz_num;
    logic        kernel_row_done;
    logic        kernel_nnz_beat;

    spmv_kernel_ctrl #(
        .TIMEOUT_CYCLES(64'd100)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .ctrl_word      (ctrl_word),
        .row_num        (row_num),
        .nnz_num        (nnz_num),
        .status_word    (status_word),
        .kernel_start   (kernel_start),
        .kernel_abort   (kernel_abort),
        .kernel_row_num (kernel_row_num),
        .kernel_nnz_num (kernel_nnz_num),
        .kernel_row_done(kernel_row_done),
        .kernel_nnz_beat(kernel_nnz_beat)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int st;
        int ec;
        int cnt;
        int rows;
        int starts;
        int aborts;
        int krow;
        int knnz;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int n_cmp = 0;
    int n_bad = 0;
    int tot_starts = 0;
    int run_starts = 0;
    int run_aborts = 0;
    logic busy_prev = 1'b0;

    bit row_p [1:120];
    bit beat_p[1:120];
    bit abrt_p[1:120];
    bit rst_p [1:120];

    task automatic check(input string nm, input logic [95:0] act,
                         input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one comparison set per busy falling edge.
    always @(negedge aclk) begin
        if (kernel_start) begin
            run_starts++;
            tot_starts++;
        end
        if (kernel_abort) run_aborts++;
        if (busy_prev && !status_word[64]) begin
            if (sb.size() == 0) begin
                check("unexpected_run_end", 1, 0);
            end else begin
                cur = sb.pop_front();
                check("state",    status_word[70:68], cur.st);
                check("err_code", status_word[73:72], cur.ec);
                check("done_flg", status_word[65], cur.st == 3);
                check("err_flg",  status_word[66], cur.st == 4);
                check("count",    status_word[63:0], cur.cnt);
                check("rows",     status_word[95:74], cur.rows);
                check("starts",   run_starts, cur.starts);
                check("aborts",   run_aborts, cur.aborts);
                check("krow",     kernel_row_num, cur.krow);
                check("knnz",     kernel_nnz_num, cur.knnz);
            end
            run_starts = 0;
            run_aborts = 0;
        end
        busy_prev = status_word[64];
    end

    task automatic clear_pulses();
        for (int i = 1; i <= 120; i++) begin
            row_p[i]  = 1'b0;
            beat_p[i] = 1'b0;
            abrt_p[i] = 1'b0;
            rst_p[i]  = 1'b0;
        end
    endtask

    // Reference: walk RUN cycles applying the outcome rules in priority order.
    task automatic model(input int R, input int N, output exp_t e,
                         output int last);
        int r;
        int b;
        r = 0;
        b = 0;
        e = '{st: 3, ec: 0, cnt: 0, rows: 0, starts: 0, aborts: 0,
              krow: R, knnz: N};
        last = 0;
        if (R == 0) return;
        e.starts = 1;
        for (int i = 1; i <= 120; i++) begin
            last = i;
            if (rst_p[i]) begin
                e = '{st: 0, ec: 0, cnt: 0, rows: 0, starts: 1, aborts: 0,
                      krow: 0, knnz: 0};
                return;
            end
            if (abrt_p[i]) begin
                e.st = 0; e.cnt = i - 1; e.rows = r; e.aborts = 1;
                return;
            end
            r += int'(row_p[i]);
            b += int'(beat_p[i]);
            e.cnt = i;
            e.rows = r;
            if (b > N) begin
                e.st = 4; e.ec = 2;
                return;
            end
            if (r == R) begin
                if (b == N) e.st = 3;
                else begin e.st = 4; e.ec = 1; end
                return;
            end
            if (i == TMO) begin
                e.st = 4; e.ec = 3; e.aborts = 1;
                return;
            end
        end
    endtask

    task automatic do_run(input int R, input int N);
        exp_t e;
        int last;
        model(R, N, e, last);
        sb.push_back(e);
        ctrl_word = 32'd0;
        @(posedge aclk); #1;
        row_num = R;
        nnz_num = N;
        ctrl_word = 32'd1;
        @(posedge aclk); #1;
        row_num = $urandom;
        nnz_num = $urandom;
        @(posedge aclk); #1;
        for (int i = 1; i <= last; i++) begin
            kernel_row_done = row_p[i];
            kernel_nnz_beat = beat_p[i];
            ctrl_word = abrt_p[i] ? 32'd3 : 32'd1;
            areset = rst_p[i];
            if (rst_p[i]) ctrl_word = 32'd0;
            @(posedge aclk); #1;
        end
        kernel_row_done = 1'b0;
        kernel_nnz_beat = 1'b0;
        areset = 1'b0;
        ctrl_word = (last > 0 && rst_p[last]) ? 32'd0 : 32'd1;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic gen_random(output int R, output int N);
        int mode;
        int b0;
        int r0;
        clear_pulses();
        R = $urandom_range(1, 6);
        N = $urandom_range(0, 12);
        mode = $urandom_range(0, 4);
        if (mode == 1 || mode == 4) begin
            for (int i = 1; i <= 60; i++) begin
                row_p[i]  = ($urandom_range(0, 5) == 0);
                beat_p[i] = ($urandom_range(0, 2) == 0);
            end
        end else begin
            b0 = $urandom_range(1, 10);
            r0 = $urandom_range(25, 40);
            for (int k = 0; k < N; k++) beat_p[b0 + k] = 1'b1;
            for (int k = 0; k < R; k++) row_p[r0 + k] = 1'b1;
        end
        if (mode == 2) abrt_p[$urandom_range(1, 40)] = 1'b1;
        if (mode == 3) beat_p[$urandom_range(1, 60)] = 1'b1;
        if (mode == 4) rst_p[$urandom_range(1, 40)] = 1'b1;
    endtask

    initial begin
        int R;
        int N;
        int s0;
        areset = 1'b1;
        ctrl_word = 32'd0;
        row_num = 32'd0;
        nnz_num = 32'd0;
        kernel_row_done = 1'b0;
        kernel_nnz_beat = 1'b0;
        clear_pulses();
        repeat (3) @(posedge aclk);
        #1;
        check("rst_status", status_word, 96'd0);
        check("rst_kstart", kernel_start, 0);
        check("rst_kabort", kernel_abort, 0);
        check("rst_krow",   kernel_row_num, 0);
        check("rst_knnz",   kernel_nnz_num, 0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // Basic launch: 10 beats, 4 rows, completes at RUN cycle 40.
        clear_pulses();
        for (int k = 1; k <= 10; k++) beat_p[2 * k] = 1'b1;
        for (int k = 1; k <= 4; k++) row_p[10 * k] = 1'b1;
        do_run(4, 10);

        // Start held high: no relaunch.
        s0 = tot_starts;
        repeat (10) @(posedge aclk);
        #1;
        check("level_hold_starts", tot_starts, s0);
        check("level_hold_state", status_word[70:68], 3);

        // Second launch restarts the count.
        clear_pulses();
        row_p[3] = 1'b1;
        do_run(1, 0);

        // Clear while DONE.
        ctrl_word = 32'd5;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        check("clear_count", status_word[63:0], 0);
        check("clear_state", status_word[70:68], 3);
        ctrl_word = 32'd1;

        // Zero rows.
        clear_pulses();
        do_run(0, 7);

        // Overrun on 4th beat.
        clear_pulses();
        for (int k = 1; k <= 4; k++) beat_p[k] = 1'b1;
        row_p[10] = 1'b1;
        do_run(2, 3);

        // nnz mismatch at completion.
        clear_pulses();
        for (int k = 1; k <= 3; k++) beat_p[k] = 1'b1;
        row_p[5] = 1'b1;
        row_p[6] = 1'b1;
        do_run(2, 5);

        // Timeout with no progress.
        clear_pulses();
        do_run(2, 2);

        // Abort mid-RUN.
        clear_pulses();
        beat_p[1] = 1'b1;
        beat_p[2] = 1'b1;
        row_p[3] = 1'b1;
        abrt_p[5] = 1'b1;
        do_run(3, 3);

        // Abort with start edge in the same cycle, then release abort.
        ctrl_word = 32'd0;
        @(posedge aclk); #1;
        s0 = tot_starts;
        ctrl_word = 32'd3;
        repeat (3) @(posedge aclk);
        #1;
        check("abort_start_starts", tot_starts, s0);
        check("abort_start_busy", status_word[64], 0);
        ctrl_word = 32'd1;
        repeat (3) @(posedge aclk);
        #1;
        check("edge_consumed_starts", tot_starts, s0);

        // Reset mid-RUN.
        clear_pulses();
        beat_p[2] = 1'b1;
        rst_p[6] = 1'b1;
        do_run(3, 3);

        for (int t = 0; t < 30; t++) begin
            gen_random(R, N);
            do_run(R, N);
        end

        for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge aclk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
